issue_scheduler: RTL and testbench

Controls the out-of-order issue buffer. It tracks which of `bs` slots are free, waiting or issued, and holds the per-slot dependency rows. It allocates slots to incoming instructions and offers ready instructions to the execution unit through a valid/ready handshake. On completion it frees the slot and clears that slot's column from every dependency row. It sits between decode (allocation side) and execute/writeback (issue and done side).

---
 rtl/issue_pkg.sv | 13 +
 rtl/lsb_select.sv | 25 ++
 rtl/issue_scheduler.sv | 140 ++++++++++++++
 tb/tb_issue_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and defaults for the out-of-order issue buffer controller.
package issue_pkg;

  localparam int unsigned BS_DEFAULT = 16;

  // Per-slot lifecycle: FREE -> WAIT (allocated) -> ISSUED (offered) -> FREE (done)
  typedef enum logic [1:0] {
    SLOT_FREE   = 2'b00,
    SLOT_WAIT   = 2'b01,
    SLOT_ISSUED = 2'b10
  } slot_state_t;

endpackage

// File: rtl/lsb_select.sv
// Lowest-set-bit finder.
// Ports: vec (input vector), found_c (any bit set), index_c (lowest set index, 0 if none).
module lsb_select #(
  parameter int unsigned width = 16
) (
  input  logic [width-1:0]         vec,
  output logic                     found_c,
  output logic [$clog2(width)-1:0] index_c
);

  localparam int unsigned iw = $clog2(width);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    found_c = 1'b0;
    index_c = '0;
    for (int i = int'(width) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found_c = 1'b1;
        index_c = iw'(i);
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Out-of-order issue buffer controller: tracks slot state and dependency rows,
// allocates slots from decode, offers ready slots to execute, frees on completion.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   alloc_valid/deps/ready/index allocation side (ready/index combinational from slot state)
//   issue_valid/index/ready      registered offer with valid/ready handshake
//   done_valid/index             completion report
//   occupancy                    count of non-FREE slots
module issue_scheduler
  import issue_pkg::*;
#(
  parameter int unsigned bs = BS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [bs-1:0]         alloc_deps,
  output logic                  alloc_ready,
  output logic [$clog2(bs)-1:0] alloc_index,
  output logic                  issue_valid,
  output logic [$clog2(bs)-1:0] issue_index,
  input  logic                  issue_ready,
  input  logic                  done_valid,
  input  logic [$clog2(bs)-1:0] done_index,
  output logic [$clog2(bs):0]   occupancy
);

  localparam int unsigned bs_bits = $clog2(bs);
  localparam int unsigned occ_w   = bs_bits + 1;

  slot_state_t         slot_state [bs];
  slot_state_t         state_next [bs];
  logic [bs-1:0]       dep        [bs];
  logic [bs-1:0]       dep_next   [bs];
  logic                valid_next;
  logic [bs_bits-1:0]  index_next;
  logic [occ_w-1:0]    occ_next;

  logic [bs-1:0]       free_vec;
  logic [bs-1:0]       ready_vec;
  logic                ready_found;
  logic [bs_bits-1:0]  ready_index;
  logic                alloc_fire;
  logic                offer_load;
  logic                done_act;
  logic [bs-1:0]       self_mask;
  logic [bs-1:0]       done_mask;
  logic [bs-1:0]       alloc_row;

  // Slot classification from registered state only
  always_comb begin
    for (int i = 0; i < int'(bs); i++) begin
      free_vec[i]  = (slot_state[i] == SLOT_FREE);
      ready_vec[i] = (slot_state[i] == SLOT_WAIT) && (dep[i] == '0);
    end
  end

  lsb_select #(.width(bs)) u_free_sel (
    .vec     (free_vec),
    .found_c (alloc_ready),
    .index_c (alloc_index)
  );

  // An accepted slot is already ISSUED, so it can never reappear in ready_vec
  lsb_select #(.width(bs)) u_ready_sel (
    .vec     (ready_vec),
    .found_c (ready_found),
    .index_c (ready_index)
  );

  // A done for the slot still sitting in the offer register is not a real completion
  always_comb begin
    alloc_fire = alloc_valid && alloc_ready;
    offer_load = !issue_valid || issue_ready;
    done_act   = done_valid && (slot_state[done_index] == SLOT_ISSUED) &&
                 !(issue_valid && (issue_index == done_index));
    self_mask              = '0;
    self_mask[alloc_index] = 1'b1;
    done_mask              = '0;
    done_mask[done_index]  = done_act;
    // Drop deps on FREE slots, on itself, and on a slot completing this cycle
    alloc_row = alloc_deps & ~free_vec & ~self_mask & ~done_mask;
  end

  // Next-state for slots, dependency rows, offer register and occupancy
  always_comb begin
    state_next = slot_state;
    dep_next   = dep;
    valid_next = issue_valid;
    index_next = issue_index;
    occ_next   = occupancy;

    if (done_act) begin
      for (int r = 0; r < int'(bs); r++) begin
        dep_next[r][done_index] = 1'b0;
      end
      state_next[done_index] = SLOT_FREE;
      dep_next[done_index]   = '0;
    end

    if (alloc_fire) begin
      state_next[alloc_index] = SLOT_WAIT;
      dep_next[alloc_index]   = alloc_row;
    end

    if (offer_load) begin
      valid_next = ready_found;
      if (ready_found) begin
        index_next              = ready_index;
        state_next[ready_index] = SLOT_ISSUED;
      end
    end

    case ({alloc_fire, done_act})
      2'b10:   occ_next = occupancy + occ_w'(1);
      2'b01:   occ_next = occupancy - occ_w'(1);
      default: occ_next = occupancy;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(bs); i++) begin
        slot_state[i] <= SLOT_FREE;
        dep[i]        <= '0;
      end
      issue_valid <= 1'b0;
      issue_index <= '0;
      occupancy   <= '0;
    end else begin
      slot_state  <= state_next;
      dep         <= dep_next;
      issue_valid <= valid_next;
      issue_index <= index_next;
      occupancy   <= occ_next;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: a vector table for the basic
// allocate/issue/done flow plus directed multi-cycle sequences.
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [15:0] alloc_deps;
  logic        alloc_ready;
  logic [3:0]  alloc_index;
  logic        issue_valid;
  logic [3:0]  issue_index;
  logic        issue_ready;
  logic        done_valid;
  logic [3:0]  done_index;
  logic [4:0]  occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  issue_scheduler #(.bs(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_deps  (alloc_deps),
    .alloc_ready (alloc_ready),
    .alloc_index (alloc_index),
    .issue_valid (issue_valid),
    .issue_index (issue_index),
    .issue_ready (issue_ready),
    .done_valid  (done_valid),
    .done_index  (done_index),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [15:0] ad;
    logic        ir;
    logic        dv;
    logic [3:0]  di;
    logic        chk;    // compare outputs seen at the start of this cycle
    logic        e_ar;
    logic [3:0]  e_ai;
    logic        e_iv;
    logic [3:0]  e_ii;
    logic [4:0]  e_occ;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then land on the next falling edge
  task automatic cyc(input logic av, input logic [15:0] ad, input logic ir,
                     input logic dv, input logic [3:0] di);
    rst         = 1'b0;
    alloc_valid = av;
    alloc_deps  = ad;
    issue_ready = ir;
    done_valid  = dv;
    done_index  = di;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    alloc_valid = 1'b0;
    alloc_deps  = '0;
    issue_ready = 1'b0;
    done_valid  = 1'b0;
    done_index  = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic r, input logic av, input logic [15:0] ad,
                              input logic ir, input logic dv, input logic [3:0] di,
                              input logic chk, input logic ar, input logic [3:0] ai,
                              input logic iv, input logic [3:0] ii, input logic [4:0] occ);
    vec_t v;
    v.rst = r; v.av = av; v.ad = ad; v.ir = ir; v.dv = dv; v.di = di;
    v.chk = chk; v.e_ar = ar; v.e_ai = ai; v.e_iv = iv; v.e_ii = ii; v.e_occ = occ;
    return v;
  endfunction

  initial begin
    rst = 1'b1; alloc_valid = 1'b0; alloc_deps = '0;
    issue_ready = 1'b0; done_valid = 1'b0; done_index = '0;
    @(negedge clk);

    //            rst av ad        ir dv di  chk ar ai iv ii occ
    vecs[0]  = mk(1, 0, 16'h0000, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 16'h0000, 1, 0, 0,  1,  1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 16'h0000, 1, 0, 0,  1,  1, 1, 0, 0, 1);
    vecs[3]  = mk(0, 1, 16'h0000, 1, 0, 0,  1,  1, 2, 1, 0, 2);
    vecs[4]  = mk(0, 0, 16'h0000, 1, 0, 0,  1,  1, 3, 1, 1, 3);
    vecs[5]  = mk(0, 0, 16'h0000, 1, 0, 0,  1,  1, 3, 1, 2, 3);
    vecs[6]  = mk(0, 0, 16'h0000, 1, 1, 0,  1,  1, 3, 0, 2, 3);
    vecs[7]  = mk(0, 0, 16'h0000, 0, 1, 1,  1,  1, 0, 0, 2, 2);
    vecs[8]  = mk(0, 0, 16'h0000, 0, 1, 2,  1,  1, 0, 0, 2, 1);
    vecs[9]  = mk(0, 0, 16'h0000, 0, 1, 7,  1,  1, 0, 0, 2, 0);  // done on FREE slot 7
    vecs[10] = mk(0, 0, 16'h0000, 0, 0, 0,  1,  1, 0, 0, 2, 0);

    for (int k = 0; k < 11; k++) begin
      rst         = vecs[k].rst;
      alloc_valid = vecs[k].av;
      alloc_deps  = vecs[k].ad;
      issue_ready = vecs[k].ir;
      done_valid  = vecs[k].dv;
      done_index  = vecs[k].di;
      if (vecs[k].chk) begin
        check($sformatf("vec%0d alloc_ready", k), 32'(alloc_ready), 32'(vecs[k].e_ar));
        check($sformatf("vec%0d alloc_index", k), 32'(alloc_index), 32'(vecs[k].e_ai));
        check($sformatf("vec%0d issue_valid", k), 32'(issue_valid), 32'(vecs[k].e_iv));
        check($sformatf("vec%0d issue_index", k), 32'(issue_index), 32'(vecs[k].e_ii));
        check($sformatf("vec%0d occupancy", k),   32'(occupancy),   32'(vecs[k].e_occ));
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Wakeup latency: slot1 depends on slot0
    do_reset();
    cyc(1, 16'h0000, 0, 0, 0);               // slot0
    cyc(1, 16'h0001, 0, 0, 0);               // slot1, offer loads slot0
    check("wake offer0_valid", 32'(issue_valid), 32'd1);
    check("wake offer0_index", 32'(issue_index), 32'd0);
    cyc(0, 16'h0000, 1, 0, 0);               // accept slot0, slot1 blocked
    check("wake blocked", 32'(issue_valid), 32'd0);
    cyc(0, 16'h0000, 1, 1, 0);               // done slot0 in cycle D
    check("wake D+1 not offered", 32'(issue_valid), 32'd0);
    check("wake occ", 32'(occupancy), 32'd1);
    cyc(0, 16'h0000, 0, 0, 0);
    check("wake D+2 valid", 32'(issue_valid), 32'd1);
    check("wake D+2 index", 32'(issue_index), 32'd1);
    cyc(0, 16'h0000, 0, 1, 1);               // done on slot held in offer: ignored
    check("done on offered occ", 32'(occupancy), 32'd1);
    check("done on offered valid", 32'(issue_valid), 32'd1);

    // Pending offer is held while a lower slot wakes up
    do_reset();
    cyc(1, 16'h0000, 1, 0, 0);               // s0
    cyc(1, 16'h0000, 1, 0, 0);               // s1
    cyc(1, 16'h0001, 1, 0, 0);               // s2 dep s0
    cyc(1, 16'h0004, 1, 0, 0);               // s3 dep s2
    check("hold pre empty", 32'(issue_valid), 32'd0);
    cyc(1, 16'h0000, 0, 0, 0);               // s4
    cyc(0, 16'h0000, 0, 1, 0);               // done s0, s4 loaded
    check("hold offer4 valid", 32'(issue_valid), 32'd1);
    check("hold offer4 index", 32'(issue_index), 32'd4);
    check("hold occ", 32'(occupancy), 32'd4);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 16'h0000, 0, 0, 0);
      check($sformatf("hold cyc%0d index", k), 32'(issue_index), 32'd4);
      check($sformatf("hold cyc%0d valid", k), 32'(issue_valid), 32'd1);
    end
    cyc(0, 16'h0000, 1, 0, 0);               // accept s4
    check("release next valid", 32'(issue_valid), 32'd1);
    check("release next index", 32'(issue_index), 32'd2);

    // Fill every slot, with back-to-back issue running
    do_reset();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("fill alloc_index%0d", k), 32'(alloc_index), 32'(k));
      cyc(1, 16'h0000, 1, 0, 0);
      if (k >= 2) begin
        check($sformatf("b2b valid%0d", k), 32'(issue_valid), 32'd1);
        check($sformatf("b2b index%0d", k), 32'(issue_index), 32'(k - 1));
      end
    end
    check("full alloc_ready", 32'(alloc_ready), 32'd0);
    check("full occ", 32'(occupancy), 32'd16);
    cyc(1, 16'h0000, 0, 0, 0);               // extra alloc ignored
    check("full extra occ", 32'(occupancy), 32'd16);
    check("full extra ready", 32'(alloc_ready), 32'd0);
    check("full offer index", 32'(issue_index), 32'd14);
    cyc(0, 16'h0000, 0, 1, 5);               // done slot5
    check("free5 ready", 32'(alloc_ready), 32'd1);
    check("free5 index", 32'(alloc_index), 32'd5);
    check("free5 occ", 32'(occupancy), 32'd15);

    // Same-cycle allocate (dep on slot3) and done slot3
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1, 16'h0000, 1, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0);
    check("same pre valid", 32'(issue_valid), 32'd0);
    check("same pre index", 32'(alloc_index), 32'd4);
    cyc(1, 16'h0008, 1, 1, 3);
    check("same occ", 32'(occupancy), 32'd4);
    check("same N+1 valid", 32'(issue_valid), 32'd0);
    cyc(0, 16'h0000, 0, 0, 0);
    check("same N+2 valid", 32'(issue_valid), 32'd1);
    check("same N+2 index", 32'(issue_index), 32'd4);

    // Reset with 6 occupied and an offer pending
    cyc(1, 16'h0000, 0, 0, 0);               // s3
    cyc(1, 16'h0000, 0, 0, 0);               // s5
    check("rst pre occ", 32'(occupancy), 32'd6);
    check("rst pre valid", 32'(issue_valid), 32'd1);
    rst = 1'b1; alloc_valid = 1'b1; alloc_deps = '0;
    issue_ready = 1'b1; done_valid = 1'b1; done_index = 4'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; alloc_valid = 1'b0; issue_ready = 1'b0; done_valid = 1'b0;
    check("rst valid", 32'(issue_valid), 32'd0);
    check("rst occ", 32'(occupancy), 32'd0);
    check("rst alloc_index", 32'(alloc_index), 32'd0);
    check("rst alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst issue_index", 32'(issue_index), 32'd0);
    cyc(0, 16'h0000, 0, 0, 0);
    check("rst idle valid", 32'(issue_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
